fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the fetch stage (pc, adder1, adder2/shft/sign_extend, mux6, instr, id_buf).
//  Drives the mux6 PC-source select, pc/id_buf write enables and id_buf flush.
//  Arbitrates load-use hazards, taken branches resolved in ID, and halt.
//  Keeps saturating stall/flush performance counters and a stall-watchdog error flag.
// PARAMETERS
//  BR_PENALTY  1    id_buf flush cycles per taken branch (1..7)
//  MAX_STALL   15   consecutive hazard cycles before err_stall sets (1..255)
//  CNT_W       8    width of performance counters
// PORTS
//  CLOCK         in   1      system clock, all state on rising edge
//  in_rst        in   1      synchronous active-high reset
//  in_haz        in   1      load-use hazard from hazard unit (ID instr must wait)
//  in_cntrl      in   1      ID instr is a branch
//  in_comp       in   1      ID comparator: branch condition true
//  in_halt       in   1      ID instr is HALT
//  cntrl_pc_src  out  1      mux6 select: 0 = adder1 (PC+1), 1 = adder2 (branch target)
//  pc_we         out  1      pc register load enable
//  ifid_we       out  1      id_buf load enable
//  ifid_flush    out  1      id_buf clear (insert NOP), wins over ifid_we
//  halted        out  1      fetch stopped by HALT
//  err_stall     out  1      sticky: hazard held > MAX_STALL cycles
//  stall_cnt     out  CNT_W  saturating count of stall cycles
//  flush_cnt     out  CNT_W  saturating count of taken branches
// BEHAVIOUR
//  States: INIT, RUN, FLUSH, HALT. Reset (any state, any cycle) -> INIT; counters,
//   err_stall, halted, watchdog = 0. Reset wins over every other input that cycle.
//  INIT: pc_we=0, ifid_we=0, ifid_flush=1, pc_src=0; next -> RUN unconditionally.
//  RUN (outputs combinational on inputs, priority high->low):
//   1 in_haz=1: pc_we=0, ifid_we=0, ifid_flush=0; stall_cnt+1; watchdog+1. Branch/halt
//     in ID ignored this cycle (operands not ready); re-evaluated when in_haz drops.
//   2 in_halt=1: pc_we=0, ifid_we=0; next -> HALT.
//   3 in_cntrl & in_comp: pc_src=1, pc_we=1, ifid_flush=1; flush_cnt+1;
//     next -> FLUSH if BR_PENALTY>1 else RUN.
//   4 else: pc_src=0, pc_we=1, ifid_we=1.
//   Watchdog clears on any RUN cycle with in_haz=0; err_stall sets the cycle watchdog
//   reaches MAX_STALL+1, stays set until reset.
//  FLUSH: pc_src=0, pc_we=1, ifid_flush=1, ifid_we=0; inputs ignored; stays
//   BR_PENALTY-1 cycles (down-counter loaded on entry), then -> RUN.
//  HALT: pc_we=0, ifid_we=0, ifid_flush=0, halted=1; exits only on reset.
//  Counters saturate at 2^CNT_W-1 (no wrap). pc_src=0 in every state except RUN rule 3.
//  Latency: branch taken in cycle T -> PC holds target at T+1; first useful instr in id_buf
//   at T+BR_PENALTY+1.
// TESTING
//  1 in_rst=1 for 2 cycles, release, no events -> cycle 0 INIT (flush=1, pc_we=0),
//    then pc_we=ifid_we=1 every cycle, pc_src=0, counters 0.
//  2 in_haz=1 for 3 cycles in RUN -> pc_we=ifid_we=0 for exactly 3 cycles, stall_cnt=3,
//    err_stall=0; 16 cycles with MAX_STALL=15 -> err_stall=1 on 16th, sticky after drop.
//  3 in_cntrl=in_comp=1 one cycle, BR_PENALTY=1 -> pc_src=1, ifid_flush=1 that cycle,
//    normal next cycle, flush_cnt=1; in_comp=0 -> no flush, flush_cnt unchanged.
//  4 BR_PENALTY=3, taken branch -> ifid_flush=1 for 3 consecutive cycles, branch inputs
//    held high during FLUSH cause no extra flush; flush_cnt=1.
//  5 in_haz=1 with in_cntrl=in_comp=1 and in_halt=1 -> stall only; drop in_haz with
//    in_halt=1 -> HALT, halted=1, pc_we=0 until reset.
//  6 reset asserted mid-FLUSH and in HALT -> next cycle INIT, all flags/counters 0;
//    drive 300 stall cycles with CNT_W=8 -> stall_cnt=255.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer. Chooses the next PC source, gates the
// pc/id_buf loads, flushes id_buf after taken branches, stops fetch on HALT,
// and keeps saturating stall/flush counters plus a stall watchdog flag.
module fetch_ctrl #(
  parameter int BR_PENALTY = 1,   // id_buf flush cycles per taken branch (1..7)
  parameter int MAX_STALL  = 15,  // hazard cycles tolerated before err_stall (1..255)
  parameter int CNT_W      = 8
) (
  input  logic             CLOCK,
  input  logic             in_rst,
  input  logic             in_haz,
  input  logic             in_cntrl,
  input  logic             in_comp,
  input  logic             in_halt,
  output logic             cntrl_pc_src,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             halted,
  output logic             err_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  // Extra FLUSH-state cycles after the branch cycle itself.
  localparam logic [2:0] FL_LOAD = 3'(BR_PENALTY - 1);
  // Watchdog value at which the current hazard cycle is the (MAX_STALL+1)th.
  localparam logic [8:0] WD_TRIP = 9'(MAX_STALL);

  logic [1:0] state, state_nxt;
  logic [2:0] fl_cnt;
  logic [8:0] wd;
  logic       err_q;
  logic       stall_ev, br_ev, wd_trip;

  // Qualified events; hazard has top priority so it masks branch and halt.
  always_comb begin
    stall_ev = (state == S_RUN) && in_haz;
    br_ev    = (state == S_RUN) && !in_haz && !in_halt && in_cntrl && in_comp;
    wd_trip  = stall_ev && (wd == WD_TRIP);
  end

  // Output decode and next-state selection.
  always_comb begin
    cntrl_pc_src = 1'b0;
    pc_we        = 1'b0;
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    state_nxt    = state;
    case (state)
      S_INIT: begin
        ifid_flush = 1'b1;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (in_haz) begin
          // hold pc and id_buf; branch/halt re-evaluated once operands are ready
        end else if (in_halt) begin
          state_nxt = S_HALT;
        end else if (in_cntrl && in_comp) begin
          cntrl_pc_src = 1'b1;
          pc_we        = 1'b1;
          ifid_flush   = 1'b1;
          state_nxt    = (BR_PENALTY > 1) ? S_FLUSH : S_RUN;
        end else begin
          pc_we   = 1'b1;
          ifid_we = 1'b1;
        end
      end
      S_FLUSH: begin
        pc_we      = 1'b1;
        ifid_flush = 1'b1;
        if (fl_cnt <= 3'd1) state_nxt = S_RUN;
      end
      default: begin
        // HALT: everything frozen until reset
      end
    endcase
  end

  // State register and FLUSH down-counter.
  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      state  <= S_INIT;
      fl_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (br_ev)                  fl_cnt <= FL_LOAD;
      else if (state == S_FLUSH)  fl_cnt <= fl_cnt - 3'd1;
    end
  end

  // Stall watchdog: counts consecutive RUN hazard cycles, error is sticky.
  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      if (stall_ev) begin
        if (wd <= WD_TRIP) wd <= wd + 9'd1;
      end else if (state == S_RUN) begin
        wd <= '0;
      end
      if (wd_trip) err_q <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge CLOCK) begin
    if (in_rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (br_ev && flush_cnt != {CNT_W{1'b1}})    flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // Error shows in the cycle the limit is crossed, then stays from the register.
  always_comb begin
    err_stall = err_q | wd_trip;
    halted    = (state == S_HALT);
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: two instances (BR_PENALTY=1 and 3) driven by the same inputs;
// expectations are queued when inputs are applied and checked at the negedge.
module tb_fetch_ctrl;

  logic       CLOCK = 1'b0;
  logic       in_rst, in_haz, in_cntrl, in_comp, in_halt;
  logic       a_src, a_pwe, a_iwe, a_fl, a_hd, a_er;
  logic       b_src, b_pwe, b_iwe, b_fl, b_hd, b_er;
  logic [7:0] a_sc, a_fc, b_sc, b_fc;

  always #5 CLOCK = ~CLOCK;

  fetch_ctrl #(.BR_PENALTY(1), .MAX_STALL(15), .CNT_W(8)) dut_a (
    .CLOCK(CLOCK), .in_rst(in_rst), .in_haz(in_haz), .in_cntrl(in_cntrl),
    .in_comp(in_comp), .in_halt(in_halt), .cntrl_pc_src(a_src), .pc_we(a_pwe),
    .ifid_we(a_iwe), .ifid_flush(a_fl), .halted(a_hd), .err_stall(a_er),
    .stall_cnt(a_sc), .flush_cnt(a_fc));

  fetch_ctrl #(.BR_PENALTY(3), .MAX_STALL(15), .CNT_W(8)) dut_b (
    .CLOCK(CLOCK), .in_rst(in_rst), .in_haz(in_haz), .in_cntrl(in_cntrl),
    .in_comp(in_comp), .in_halt(in_halt), .cntrl_pc_src(b_src), .pc_we(b_pwe),
    .ifid_we(b_iwe), .ifid_flush(b_fl), .halted(b_hd), .err_stall(b_er),
    .stall_cnt(b_sc), .flush_cnt(b_fc));

  typedef struct packed {
    logic       rst, haz, cntrl, comp, halt;
    logic       chk;
    logic [5:0] flags;   // {pc_src, pc_we, ifid_we, ifid_flush, halted, err_stall}
    logic [7:0] sc, fc;
  } vec_t;

  typedef struct {
    int         id;
    logic       sel;
    logic [5:0] flags;
    logic [7:0] sc, fc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic sel      = 1'b0;
  int   step_id  = 0;

  // Apply one cycle of inputs right after the edge and queue what must be seen.
  task automatic step(input vec_t v);
    exp_t e;
    @(posedge CLOCK);
    #1;
    in_rst = v.rst; in_haz = v.haz; in_cntrl = v.cntrl; in_comp = v.comp; in_halt = v.halt;
    step_id++;
    if (v.chk) begin
      e.id = step_id; e.sel = sel; e.flags = v.flags; e.sc = v.sc; e.fc = v.fc;
      q.push_back(e);
    end
  endtask

  // Pop and compare against the selected instance mid-cycle.
  always @(negedge CLOCK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [5:0] f;
      logic [7:0] sc, fc;
      e  = q.pop_front();
      f  = e.sel ? {b_src, b_pwe, b_iwe, b_fl, b_hd, b_er} : {a_src, a_pwe, a_iwe, a_fl, a_hd, a_er};
      sc = e.sel ? b_sc : a_sc;
      fc = e.sel ? b_fc : a_fc;
      n_checks += 3;
      if (f !== e.flags) begin
        n_fail++;
        $display("FAIL flags step %0d dut%0d: got %b want %b (src,pwe,iwe,flush,halted,err)",
                 e.id, e.sel, f, e.flags);
      end
      if (sc !== e.sc) begin
        n_fail++;
        $display("FAIL stall_cnt step %0d dut%0d: got %0d want %0d", e.id, e.sel, sc, e.sc);
      end
      if (fc !== e.fc) begin
        n_fail++;
        $display("FAIL flush_cnt step %0d dut%0d: got %0d want %0d", e.id, e.sel, fc, e.fc);
      end
    end
  end

  localparam logic [5:0] F_NORM = 6'b011000;
  localparam logic [5:0] F_INIT = 6'b000100;
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_BR   = 6'b110100;
  localparam logic [5:0] F_FL   = 6'b010100;
  localparam logic [5:0] F_HALT = 6'b000010;

  vec_t tbl[20];

  initial begin
    in_rst = 1'b1; in_haz = 1'b0; in_cntrl = 1'b0; in_comp = 1'b0; in_halt = 1'b0;

    //           rst haz cn cp hl chk flags   sc  fc
    tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, F_NONE, 8'd0, 8'd0};
    tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, F_NONE, 8'd0, 8'd0};
    tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_INIT, 8'd0, 8'd0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd0};
    tbl[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, F_NONE, 8'd0, 8'd0};
    tbl[6]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, F_NONE, 8'd1, 8'd0};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, F_NONE, 8'd2, 8'd0};
    tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd3, 8'd0};
    tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, F_BR,   8'd3, 8'd0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd3, 8'd1};
    tbl[11] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1, F_NORM, 8'd3, 8'd1};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd3, 8'd1};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1, F_NONE, 8'd3, 8'd1};
    tbl[14] = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1, F_NONE, 8'd4, 8'd1};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b1, F_HALT, 8'd4, 8'd1};
    tbl[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_HALT, 8'd4, 8'd1};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1, F_HALT, 8'd4, 8'd1};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_INIT, 8'd0, 8'd0};
    tbl[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd0};

    sel = 1'b0;
    for (int i = 0; i < 20; i++) step(tbl[i]);

    // Watchdog: 16 hazard cycles, error appears on the 16th and sticks.
    for (int i = 0; i < 16; i++)
      step('{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, (i == 15) ? 6'b000001 : F_NONE, 8'(i), 8'd0});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM | 6'b000001, 8'd16, 8'd0});

    // Stall counter saturation over 300 hazard cycles.
    for (int i = 0; i < 300; i++)
      step('{1'b0,1'b1,1'b0,1'b0,1'b0, 1'b1, 6'b000001, (16 + i > 255) ? 8'd255 : 8'(16 + i), 8'd0});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM | 6'b000001, 8'd255, 8'd0});

    // BR_PENALTY=3 instance: three flush cycles, held branch inputs ignored in FLUSH.
    sel = 1'b1;
    step('{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0, F_NONE, 8'd0, 8'd0});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_INIT, 8'd0, 8'd0});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd0});
    step('{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, F_BR,   8'd0, 8'd0});
    step('{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, F_FL,   8'd0, 8'd1});
    step('{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1, F_FL,   8'd0, 8'd1});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd1});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd1});

    // Reset during FLUSH returns to INIT with counters cleared.
    step('{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b1, F_BR,   8'd0, 8'd1});
    step('{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b1, F_FL,   8'd0, 8'd2});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_INIT, 8'd0, 8'd0});
    step('{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, F_NORM, 8'd0, 8'd0});

    @(posedge CLOCK);
    @(posedge CLOCK);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
